// File: rtl/code_tx_sequencer_pkg.sv
// Shared definitions for the code transmitter sequencer.
//   seq_state_e     : sequencer FSM state encoding
//   DEFAULT_MAX_DIG : default upper bound on the number of code digits
package code_tx_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2,
    GAP    = 2'd3
  } seq_state_e;

  localparam int DEFAULT_MAX_DIG = 32;

endpackage

// File: rtl/code_tx_sequencer_cfg_shadow.sv
// Double-buffered code configuration for the transmitter sequencer.
// A write is validated and captured into the shadow copy; the active copy
// (which drives code_top) is refreshed from the shadow only when i_apply is
// high, so the transmitter never sees a change mid-frame.
// Ports:
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_cfg_wr            : one-cycle write strobe for the i_cfg_* words
//   i_cfg_*             : code word, digit count, digit time, PRI, burst length
//   i_apply             : copy shadow -> active on this edge
//   o_codigo/o_numdig/o_tb/o_pri/o_npulses : active configuration
//   o_shadow_valid      : a valid configuration has been captured since reset
//   o_cfg_err           : one-cycle pulse after a rejected write
module code_cfg_shadow
  import code_tx_sequencer_pkg::*;
#(
  parameter int W       = 32,
  parameter int MAX_DIG = DEFAULT_MAX_DIG
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_cfg_wr,
  input  logic [W-1:0] i_cfg_codigo,
  input  logic [W-1:0] i_cfg_numdig,
  input  logic [W-1:0] i_cfg_tb,
  input  logic [W-1:0] i_cfg_pri,
  input  logic [W-1:0] i_cfg_npulses,
  input  logic         i_apply,
  output logic [W-1:0] o_codigo,
  output logic [W-1:0] o_numdig,
  output logic [W-1:0] o_tb,
  output logic [W-1:0] o_pri,
  output logic [W-1:0] o_npulses,
  output logic         o_shadow_valid,
  output logic         o_cfg_err
);

  localparam logic [2*W-1:0] MaxDigWide = (2*W)'(MAX_DIG);

  logic [W-1:0]   shadowCodigo_q, shadowNumdig_q, shadowTb_q, shadowPri_q, shadowNpulses_q;
  logic [W-1:0]   activeCodigo_q, activeNumdig_q, activeTb_q, activePri_q, activeNpulses_q;
  logic           shadowValid_q;
  logic           cfgErr_q;
  logic [2*W-1:0] digitProduct;
  logic [2*W-1:0] priWide;
  logic [2*W-1:0] numdigWide;
  logic           cfgValid;

  // The code window is numdig*tb clocks; it is formed at double width so a
  // huge product can never wrap around and sneak past the PRI check. Two
  // extra clocks cover the sync cycle and at least one gap cycle.
  always_comb begin
    numdigWide   = {{W{1'b0}}, i_cfg_numdig};
    digitProduct = numdigWide * {{W{1'b0}}, i_cfg_tb};
    priWide      = {{W{1'b0}}, i_cfg_pri};
    cfgValid     = (i_cfg_numdig != '0) && (numdigWide <= MaxDigWide) &&
                   (i_cfg_tb != '0) && (priWide >= digitProduct + (2*W)'(2));
  end

  // Apply copies the shadow as it was before this edge, so a write landing
  // on an apply cycle only reaches the transmitter at the following apply.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shadowCodigo_q  <= '0;
      shadowNumdig_q  <= '0;
      shadowTb_q      <= '0;
      shadowPri_q     <= '0;
      shadowNpulses_q <= '0;
      activeCodigo_q  <= '0;
      activeNumdig_q  <= '0;
      activeTb_q      <= '0;
      activePri_q     <= '0;
      activeNpulses_q <= '0;
      shadowValid_q   <= 1'b0;
      cfgErr_q        <= 1'b0;
    end else begin
      cfgErr_q <= i_cfg_wr && !cfgValid;
      if (i_cfg_wr && cfgValid) begin
        shadowCodigo_q  <= i_cfg_codigo;
        shadowNumdig_q  <= i_cfg_numdig;
        shadowTb_q      <= i_cfg_tb;
        shadowPri_q     <= i_cfg_pri;
        shadowNpulses_q <= i_cfg_npulses;
        shadowValid_q   <= 1'b1;
      end
      if (i_apply) begin
        activeCodigo_q  <= shadowCodigo_q;
        activeNumdig_q  <= shadowNumdig_q;
        activeTb_q      <= shadowTb_q;
        activePri_q     <= shadowPri_q;
        activeNpulses_q <= shadowNpulses_q;
      end
    end
  end

  assign o_codigo       = activeCodigo_q;
  assign o_numdig       = activeNumdig_q;
  assign o_tb           = activeTb_q;
  assign o_pri          = activePri_q;
  assign o_npulses      = activeNpulses_q;
  assign o_shadow_valid = shadowValid_q;
  assign o_cfg_err      = cfgErr_q;

endmodule

// File: rtl/code_tx_sequencer.sv
// Burst controller in front of the code_top transmitter chain.
// Emits a one-cycle sync pulse every PRI clocks, flags the code window,
// counts pulses per burst and swaps in new configuration only on PRI
// boundaries.
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_enable       : run bursts while high; stops at the next PRI boundary
//   i_cfg_wr, i_cfg_* : configuration write port
//   o_codigo, o_numdig, o_tb : active configuration for code_top
//   o_sinc         : sync pulse, o_tx_active : code window
//   o_busy         : not idle, o_pulse_cnt : pulses in current burst
//   o_done         : finite burst finished, o_cfg_err : write rejected
module code_tx_sequencer
  import code_tx_sequencer_pkg::*;
#(
  parameter int W       = 32,
  parameter int MAX_DIG = DEFAULT_MAX_DIG
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_enable,
  input  logic         i_cfg_wr,
  input  logic [W-1:0] i_cfg_codigo,
  input  logic [W-1:0] i_cfg_numdig,
  input  logic [W-1:0] i_cfg_tb,
  input  logic [W-1:0] i_cfg_pri,
  input  logic [W-1:0] i_cfg_npulses,
  output logic [W-1:0] o_codigo,
  output logic [W-1:0] o_numdig,
  output logic [W-1:0] o_tb,
  output logic         o_sinc,
  output logic         o_tx_active,
  output logic         o_busy,
  output logic [W-1:0] o_pulse_cnt,
  output logic         o_done,
  output logic         o_cfg_err
);

  seq_state_e     state_q, state_d;
  logic [W-1:0]   priCnt_q, priCnt_d;
  logic [W-1:0]   pulseCnt_q, pulseCnt_d;
  logic           sinc_q, txActive_q, busy_q, done_q;
  logic           doneNext;
  logic [W-1:0]   activePri, activeNpulses;
  logic           shadowValid;
  logic           priLast;
  logic           burstDone;
  logic           applyCfg;
  logic [2*W-1:0] windowLen;

  // In IDLE the active copy simply tracks the shadow; while running it
  // only moves on the final clock of a PRI.
  assign priLast   = (state_q == GAP) && (priCnt_q == activePri - W'(1));
  assign burstDone = (activeNpulses != '0) && (pulseCnt_q == activeNpulses);
  assign applyCfg  = (state_q == IDLE) || priLast;
  assign windowLen = {{W{1'b0}}, o_numdig} * {{W{1'b0}}, o_tb};

  code_cfg_shadow #(
    .W       (W),
    .MAX_DIG (MAX_DIG)
  ) u_cfg_shadow (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_cfg_wr       (i_cfg_wr),
    .i_cfg_codigo   (i_cfg_codigo),
    .i_cfg_numdig   (i_cfg_numdig),
    .i_cfg_tb       (i_cfg_tb),
    .i_cfg_pri      (i_cfg_pri),
    .i_cfg_npulses  (i_cfg_npulses),
    .i_apply        (applyCfg),
    .o_codigo       (o_codigo),
    .o_numdig       (o_numdig),
    .o_tb           (o_tb),
    .o_pri          (activePri),
    .o_npulses      (activeNpulses),
    .o_shadow_valid (shadowValid),
    .o_cfg_err      (o_cfg_err)
  );

  // Next-state logic. pri_cnt is 0 in the sync cycle, 1..numdig*tb through
  // the code window and runs on to pri-1 in the gap.
  always_comb begin
    state_d    = state_q;
    priCnt_d   = priCnt_q + W'(1);
    pulseCnt_d = pulseCnt_q;
    case (state_q)
      IDLE: begin
        priCnt_d = '0;
        if (i_enable && shadowValid) begin
          state_d    = SYNC;
          pulseCnt_d = W'(1);
        end
      end
      SYNC: state_d = ACTIVE;
      ACTIVE: begin
        if ({{W{1'b0}}, priCnt_q} == windowLen) state_d = GAP;
      end
      GAP: begin
        if (priLast) begin
          priCnt_d = '0;
          if (burstDone || !i_enable) begin
            state_d = IDLE;
          end else begin
            state_d    = SYNC;
            pulseCnt_d = pulseCnt_q + W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // o_done lines up with the final gap cycle, so it is predicted one clock
    // ahead from the next-state values.
    doneNext = (state_d == GAP) && (priCnt_d == activePri - W'(1)) &&
               (activeNpulses != '0) && (pulseCnt_d == activeNpulses);
  end

  // State, counters and all status outputs are registered together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      priCnt_q   <= '0;
      pulseCnt_q <= '0;
      sinc_q     <= 1'b0;
      txActive_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      priCnt_q   <= priCnt_d;
      pulseCnt_q <= pulseCnt_d;
      sinc_q     <= (state_d == SYNC);
      txActive_q <= (state_d == ACTIVE);
      busy_q     <= (state_d != IDLE);
      done_q     <= doneNext;
    end
  end

  assign o_sinc      = sinc_q;
  assign o_tx_active = txActive_q;
  assign o_busy      = busy_q;
  assign o_pulse_cnt = pulseCnt_q;
  assign o_done      = done_q;

endmodule
